// File: rtl/tcp_rx_payload_mover.sv
// Moves a TCP payload from temp-buffer slab lines into a flow receive buffer,
// then releases the slab and reports completion.
module tcp_rx_payload_mover #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned TMP_ADDR_W = 8,
  parameter int unsigned DST_ADDR_W = 16,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FLOWID_W   = 6
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic [TMP_ADDR_W-1:0]   req_slab_addr,
  input  logic [LEN_W-1:0]        req_len,
  input  logic [DST_ADDR_W-1:0]   req_dst_addr,
  input  logic [FLOWID_W-1:0]     req_flowid,

  output logic                    rd_req_val,
  input  logic                    rd_req_rdy,
  output logic [TMP_ADDR_W-1:0]   rd_req_addr,

  input  logic                    rd_resp_val,
  output logic                    rd_resp_rdy,
  input  logic [DATA_W-1:0]       rd_resp_data,

  output logic                    wr_req_val,
  input  logic                    wr_req_rdy,
  output logic [DST_ADDR_W-1:0]   wr_req_addr,
  output logic [DATA_W-1:0]       wr_req_data,
  output logic [DATA_W/8-1:0]     wr_req_mask,

  output logic                    free_val,
  input  logic                    free_rdy,
  output logic [TMP_ADDR_W-1:0]   free_addr,

  output logic                    done_val,
  input  logic                    done_rdy,
  output logic [FLOWID_W-1:0]     done_flowid,
  output logic [LEN_W-1:0]        done_len
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  typedef enum logic [1:0] {StIdle, StCopy, StFree, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    active_q;
  logic [TMP_ADDR_W-1:0]   slab_q, slab_d;
  logic [DST_ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [FLOWID_W-1:0]     flowid_q, flowid_d;
  logic [LEN_W-1:0]        lines_q, lines_d;
  logic [LEN_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0]        wr_cnt_q, wr_cnt_d;

  logic [LEN_W-1:0]        req_lines;
  logic [OFF_W-1:0]        rem;
  logic [BYTES-1:0]        all_ones;
  logic [BYTES-1:0]        last_mask;
  logic                    wr_last;

  // Line count rounds up on any partial trailing line.
  assign req_lines = (req_len >> OFF_W) + LEN_W'(|req_len[OFF_W-1:0]);
  assign rem       = len_q[OFF_W-1:0];
  assign all_ones  = '1;
  // Byte 0 sits at the mask MSB, so a partial line keeps the top rem bits.
  assign last_mask = (rem == '0) ? all_ones : ~(all_ones >> rem);
  assign wr_last   = (wr_cnt_q == lines_q - LEN_W'(1));

  assign done_flowid = flowid_q;
  assign done_len    = len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      active_q <= 1'b0;
      slab_q   <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      flowid_q <= '0;
      lines_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      slab_q   <= slab_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      flowid_q <= flowid_d;
      lines_q  <= lines_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slab_d      = slab_q;
    dst_d       = dst_q;
    len_d       = len_q;
    flowid_d    = flowid_q;
    lines_d     = lines_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    req_rdy     = 1'b0;
    rd_req_val  = 1'b0;
    rd_req_addr = '0;
    rd_resp_rdy = 1'b0;
    wr_req_val  = 1'b0;
    wr_req_addr = '0;
    wr_req_data = '0;
    wr_req_mask = '0;
    free_val    = 1'b0;
    free_addr   = '0;
    done_val    = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_rdy = active_q;
        if (req_val && active_q) begin
          slab_d   = req_slab_addr;
          dst_d    = req_dst_addr;
          len_d    = req_len;
          flowid_d = req_flowid;
          lines_d  = req_lines;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = (req_lines != '0) ? StCopy : StFree;
        end
      end
      StCopy: begin
        rd_req_val  = (rd_cnt_q < lines_q);
        rd_req_addr = slab_q + TMP_ADDR_W'(rd_cnt_q);
        if (rd_req_val && rd_req_rdy) begin
          rd_cnt_d = rd_cnt_q + LEN_W'(1);
        end
        // Read responses stream straight through to the write port.
        wr_req_val  = rd_resp_val;
        rd_resp_rdy = wr_req_rdy;
        wr_req_data = rd_resp_data;
        wr_req_addr = dst_q + DST_ADDR_W'(wr_cnt_q);
        wr_req_mask = wr_last ? last_mask : all_ones;
        if (wr_req_val && wr_req_rdy) begin
          wr_cnt_d = wr_cnt_q + LEN_W'(1);
          if (wr_last) begin
            state_d = StFree;
          end
        end
      end
      StFree: begin
        free_val  = 1'b1;
        free_addr = slab_q;
        if (free_rdy) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_val = 1'b1;
        if (done_rdy) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_tcp_rx_payload_mover.sv
// Directed bench for tcp_rx_payload_mover: temp-buffer responder, handshake logs,
// and per-scenario tasks with hand-computed expectations.
`timescale 1ns/1ps
module tb_tcp_rx_payload_mover;

  localparam int DATA_W = 512;
  localparam int BYTES  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_val = 1'b0;
  logic              req_rdy;
  logic [7:0]        req_slab_addr = '0;
  logic [15:0]       req_len = '0;
  logic [15:0]       req_dst_addr = '0;
  logic [5:0]        req_flowid = '0;
  logic              rd_req_val;
  logic              rd_req_rdy = 1'b1;
  logic [7:0]        rd_req_addr;
  logic              rd_resp_val = 1'b0;
  logic              rd_resp_rdy;
  logic [DATA_W-1:0] rd_resp_data = '0;
  logic              wr_req_val;
  logic              wr_req_rdy = 1'b1;
  logic [15:0]       wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic [BYTES-1:0]  wr_req_mask;
  logic              free_val;
  logic              free_rdy = 1'b1;
  logic [7:0]        free_addr;
  logic              done_val;
  logic              done_rdy = 1'b1;
  logic [5:0]        done_flowid;
  logic [15:0]       done_len;

  int checks = 0;
  int errors = 0;
  bit rd_stall_mode = 1'b0;

  logic [7:0]        pending[$];
  logic [7:0]        rd_log[$];
  logic [15:0]       wr_addr_log[$];
  logic [DATA_W-1:0] wr_data_log[$];
  logic [BYTES-1:0]  wr_mask_log[$];
  logic [7:0]        free_log[$];
  logic [5:0]        done_flow_log[$];
  logic [15:0]       done_len_log[$];

  tcp_rx_payload_mover dut (
    .clk           (clk),
    .rst           (rst),
    .req_val       (req_val),
    .req_rdy       (req_rdy),
    .req_slab_addr (req_slab_addr),
    .req_len       (req_len),
    .req_dst_addr  (req_dst_addr),
    .req_flowid    (req_flowid),
    .rd_req_val    (rd_req_val),
    .rd_req_rdy    (rd_req_rdy),
    .rd_req_addr   (rd_req_addr),
    .rd_resp_val   (rd_resp_val),
    .rd_resp_rdy   (rd_resp_rdy),
    .rd_resp_data  (rd_resp_data),
    .wr_req_val    (wr_req_val),
    .wr_req_rdy    (wr_req_rdy),
    .wr_req_addr   (wr_req_addr),
    .wr_req_data   (wr_req_data),
    .wr_req_mask   (wr_req_mask),
    .free_val      (free_val),
    .free_rdy      (free_rdy),
    .free_addr     (free_addr),
    .done_val      (done_val),
    .done_rdy      (done_rdy),
    .done_flowid   (done_flowid),
    .done_len      (done_len)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] line_data(input logic [7:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W / 32; i++) begin
      d[i*32 +: 32] = {a, 8'(i) ^ 8'h5A, ~a, 8'hC3};
    end
    return d;
  endfunction

  // Temp-buffer model: one-cycle latency, in-order responses.
  always @(posedge clk) begin
    #1;
    if (!rst) pending.delete();
    rd_req_rdy   = rd_stall_mode ? ~rd_req_rdy : 1'b1;
    rd_resp_val  = rst && (pending.size() > 0);
    rd_resp_data = (pending.size() > 0) ? line_data(pending[0]) : '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (rd_req_val && rd_req_rdy) begin
        pending.push_back(rd_req_addr);
        rd_log.push_back(rd_req_addr);
      end
      if (rd_resp_val && rd_resp_rdy) void'(pending.pop_front());
      if (wr_req_val && wr_req_rdy) begin
        wr_addr_log.push_back(wr_req_addr);
        wr_data_log.push_back(wr_req_data);
        wr_mask_log.push_back(wr_req_mask);
      end
      if (free_val && free_rdy) free_log.push_back(free_addr);
      if (done_val && done_rdy) begin
        done_flow_log.push_back(done_flowid);
        done_len_log.push_back(done_len);
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_mask_log.delete();
    free_log.delete();
    done_flow_log.delete();
    done_len_log.delete();
  endtask

  task automatic send_req(input logic [7:0] slab, input logic [15:0] len,
                          input logic [15:0] dst, input logic [5:0] flow);
    @(posedge clk); #1;
    req_val = 1'b1; req_slab_addr = slab; req_len = len; req_dst_addr = dst; req_flowid = flow;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (req_rdy) break;
    end
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic wait_done(input int n_before, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (done_flow_log.size() > n_before) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_req_rdy: got %b expected 0", req_rdy);
    end
    checks++;
    if ({rd_req_val, rd_resp_rdy, wr_req_val, free_val, done_val} !== 5'b0) begin
      errors++;
      $display("FAIL reset_valids: got %b expected 00000",
               {rd_req_val, rd_resp_rdy, wr_req_val, free_val, done_val});
    end
    checks++;
    if (wr_req_mask !== '0 || wr_req_data !== '0) begin
      errors++; $display("FAIL reset_mask_data: got mask %h expected 0", wr_req_mask);
    end
    checks++;
    if ({rd_req_addr, wr_req_addr, free_addr, done_flowid, done_len} !== '0) begin
      errors++;
      $display("FAIL reset_addr_fields: got %h expected 0",
               {rd_req_addr, wr_req_addr, free_addr, done_flowid, done_len});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_release_req_rdy: got %b expected 1", req_rdy);
    end
  endtask

  task automatic test_basic();
    bit to;
    logic [BYTES-1:0] exp_mask;
    clear_logs();
    send_req(8'h10, 16'd130, 16'h0200, 6'd3);
    wait_done(0, 200, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++;
    if (rd_log.size() != 3 || wr_addr_log.size() != 3) begin
      errors++;
      $display("FAIL basic_counts: got %0d reads %0d writes expected 3 3",
               rd_log.size(), wr_addr_log.size());
    end
    for (int i = 0; i < 3 && i < rd_log.size(); i++) begin
      checks++;
      if (rd_log[i] !== 8'(8'h10 + i)) begin
        errors++; $display("FAIL basic_rd_addr[%0d]: got %h expected %h", i, rd_log[i], 8'h10 + i);
      end
    end
    for (int i = 0; i < 3 && i < wr_addr_log.size(); i++) begin
      exp_mask = (i == 2) ? 64'hC000_0000_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
      checks++;
      if (wr_addr_log[i] !== 16'(16'h0200 + i) || wr_mask_log[i] !== exp_mask ||
          wr_data_log[i] !== line_data(8'(8'h10 + i))) begin
        errors++;
        $display("FAIL basic_write[%0d]: got addr %h mask %h expected addr %h mask %h",
                 i, wr_addr_log[i], wr_mask_log[i], 16'h0200 + i, exp_mask);
      end
    end
    checks++;
    if (free_log.size() != 1 || free_log[0] !== 8'h10) begin
      errors++; $display("FAIL basic_free: got %0d frees expected one of 10", free_log.size());
    end
    checks++;
    if (!to && (done_flow_log[0] !== 6'd3 || done_len_log[0] !== 16'd130)) begin
      errors++;
      $display("FAIL basic_done: got flow %0d len %0d expected 3 130",
               done_flow_log[0], done_len_log[0]);
    end
  endtask

  task automatic test_zero_len();
    bit to;
    clear_logs();
    send_req(8'h33, 16'd0, 16'h0700, 6'd5);
    wait_done(0, 50, to);
    checks++;
    if (to) begin errors++; $display("FAIL zero_timeout: got no done expected done"); end
    checks++;
    if (rd_log.size() != 0 || wr_addr_log.size() != 0) begin
      errors++;
      $display("FAIL zero_traffic: got %0d reads %0d writes expected 0 0",
               rd_log.size(), wr_addr_log.size());
    end
    checks++;
    if (free_log.size() != 1 || free_log[0] !== 8'h33) begin
      errors++; $display("FAIL zero_free: got %0d frees expected one of 33", free_log.size());
    end
    checks++;
    if (!to && (done_flow_log[0] !== 6'd5 || done_len_log[0] !== 16'd0)) begin
      errors++;
      $display("FAIL zero_done: got flow %0d len %0d expected 5 0",
               done_flow_log[0], done_len_log[0]);
    end
  endtask

  task automatic test_wr_stall();
    bit prev_stall;
    int stall_checks;
    logic [15:0] s_addr;
    logic [DATA_W-1:0] s_data;
    logic [BYTES-1:0] s_mask;
    clear_logs();
    prev_stall = 1'b0;
    stall_checks = 0;
    send_req(8'h60, 16'd128, 16'h0400, 6'd11);
    for (int c = 0; c < 200; c++) begin
      wr_req_rdy = ~wr_req_rdy;
      @(negedge clk);
      if (prev_stall) begin
        stall_checks++;
        checks++;
        if (wr_req_val !== 1'b1 || wr_req_addr !== s_addr || wr_req_data !== s_data ||
            wr_req_mask !== s_mask) begin
          errors++;
          $display("FAIL stall_hold: got val %b addr %h expected val 1 addr %h",
                   wr_req_val, wr_req_addr, s_addr);
        end
      end
      prev_stall = wr_req_val && !wr_req_rdy;
      s_addr = wr_req_addr; s_data = wr_req_data; s_mask = wr_req_mask;
      @(posedge clk); #1;
      if (done_flow_log.size() > 0) break;
    end
    wr_req_rdy = 1'b1;
    checks++;
    if (stall_checks == 0 || done_flow_log.size() != 1) begin
      errors++;
      $display("FAIL stall_progress: got %0d stalls %0d dones expected >0 1",
               stall_checks, done_flow_log.size());
    end
    checks++;
    if (wr_addr_log.size() != 2) begin
      errors++; $display("FAIL stall_count: got %0d writes expected 2", wr_addr_log.size());
    end
    for (int i = 0; i < 2 && i < wr_addr_log.size(); i++) begin
      checks++;
      if (wr_addr_log[i] !== 16'(16'h0400 + i) || wr_mask_log[i] !== 64'hFFFF_FFFF_FFFF_FFFF ||
          wr_data_log[i] !== line_data(8'(8'h60 + i))) begin
        errors++;
        $display("FAIL stall_write[%0d]: got addr %h mask %h expected addr %h mask all ones",
                 i, wr_addr_log[i], wr_mask_log[i], 16'h0400 + i);
      end
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [7:0]  exp_rd[3];
    logic [15:0] exp_wr[3];
    exp_rd = '{8'hFF, 8'h00, 8'h01};
    exp_wr = '{16'hFFFF, 16'h0000, 16'h0001};
    clear_logs();
    rd_stall_mode = 1'b1;
    send_req(8'hFF, 16'd192, 16'hFFFF, 6'd2);
    wait_done(0, 200, to);
    rd_stall_mode = 1'b0;
    checks++;
    if (to || rd_log.size() != 3 || wr_addr_log.size() != 3) begin
      errors++;
      $display("FAIL wrap_counts: got %0d reads %0d writes expected 3 3",
               rd_log.size(), wr_addr_log.size());
    end
    for (int i = 0; i < 3 && i < rd_log.size(); i++) begin
      checks++;
      if (rd_log[i] !== exp_rd[i]) begin
        errors++; $display("FAIL wrap_rd_addr[%0d]: got %h expected %h", i, rd_log[i], exp_rd[i]);
      end
    end
    for (int i = 0; i < 3 && i < wr_addr_log.size(); i++) begin
      checks++;
      if (wr_addr_log[i] !== exp_wr[i] || wr_mask_log[i] !== 64'hFFFF_FFFF_FFFF_FFFF ||
          wr_data_log[i] !== line_data(exp_rd[i])) begin
        errors++;
        $display("FAIL wrap_write[%0d]: got addr %h mask %h expected addr %h mask all ones",
                 i, wr_addr_log[i], wr_mask_log[i], exp_wr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_logs();
    @(posedge clk); #1;
    free_rdy = 1'b0; done_rdy = 1'b0;
    send_req(8'h20, 16'd64, 16'h0800, 6'd4);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (free_val) break;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (free_val !== 1'b1 || req_rdy !== 1'b0 || free_addr !== 8'h20) begin
        errors++;
        $display("FAIL bp_free_hold[%0d]: got val %b rdy %b addr %h expected 1 0 20",
                 i, free_val, req_rdy, free_addr);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 free_rdy = 1'b1;
    @(posedge clk); #1 free_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (done_val !== 1'b1 || req_rdy !== 1'b0 || done_flowid !== 6'd4 || done_len !== 16'd64) begin
        errors++;
        $display("FAIL bp_done_hold[%0d]: got val %b rdy %b flow %0d len %0d expected 1 0 4 64",
                 i, done_val, req_rdy, done_flowid, done_len);
      end
    end
    @(posedge clk); #1;
    done_rdy = 1'b1; free_rdy = 1'b1;
    req_val = 1'b1; req_slab_addr = 8'h30; req_len = 16'd64; req_dst_addr = 16'h0500;
    req_flowid = 6'd9;
    @(posedge clk); #1;
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++; $display("FAIL bp_idle_return_rdy: got %b expected 1", req_rdy);
    end
    @(posedge clk); #1;
    req_val = 1'b0;
    wait_done(1, 100, to);
    checks++;
    if (to || free_log.size() != 2 || free_log[0] !== 8'h20 || free_log[1] !== 8'h30) begin
      errors++; $display("FAIL bp_frees: got %0d frees expected 20 then 30", free_log.size());
    end
    checks++;
    if (!to && (done_flow_log[0] !== 6'd4 || done_flow_log[1] !== 6'd9 ||
                done_len_log[1] !== 16'd64)) begin
      errors++;
      $display("FAIL bp_dones: got flows %0d %0d expected 4 9", done_flow_log[0], done_flow_log[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_logs();
    send_req(8'h40, 16'd256, 16'h0100, 6'd1);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (wr_addr_log.size() >= 1) break;
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({req_rdy, rd_req_val, wr_req_val, free_val, done_val, rd_resp_rdy} !== 6'b0 ||
        wr_req_mask !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected 000000",
               {req_rdy, rd_req_val, wr_req_val, free_val, done_val, rd_resp_rdy});
    end
    checks++;
    if (wr_addr_log.size() != 1) begin
      errors++; $display("FAIL mid_reset_writes: got %0d expected 1", wr_addr_log.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    checks++;
    if (free_log.size() != 0 || done_flow_log.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_abandon: got %0d frees %0d dones expected 0 0",
               free_log.size(), done_flow_log.size());
    end
    clear_logs();
    send_req(8'h50, 16'd100, 16'h0300, 6'd7);
    wait_done(0, 100, to);
    checks++;
    if (to || wr_addr_log.size() != 2) begin
      errors++; $display("FAIL mid_after_count: got %0d writes expected 2", wr_addr_log.size());
    end
    checks++;
    if (wr_addr_log.size() == 2 &&
        (wr_addr_log[1] !== 16'h0301 || wr_mask_log[1] !== 64'hFFFF_FFFF_F000_0000 ||
         wr_data_log[1] !== line_data(8'h51))) begin
      errors++;
      $display("FAIL mid_after_last: got addr %h mask %h expected 0301 fffffffff0000000",
               wr_addr_log[1], wr_mask_log[1]);
    end
    checks++;
    if (!to && (free_log[0] !== 8'h50 || done_flow_log[0] !== 6'd7 || done_len_log[0] !== 16'd100))
    begin
      errors++;
      $display("FAIL mid_after_done: got free %h flow %0d len %0d expected 50 7 100",
               free_log[0], done_flow_log[0], done_len_log[0]);
    end
  endtask

  task automatic test_max_len();
    bit to;
    int bad;
    clear_logs();
    bad = 0;
    send_req(8'h00, 16'hFFFF, 16'h1000, 6'd63);
    wait_done(0, 3000, to);
    checks++;
    if (to || wr_addr_log.size() != 1024 || rd_log.size() != 1024) begin
      errors++;
      $display("FAIL max_counts: got %0d reads %0d writes expected 1024 1024",
               rd_log.size(), wr_addr_log.size());
    end
    for (int i = 0; i < wr_addr_log.size() && i < 1024; i++) begin
      checks++;
      if (wr_addr_log[i] !== 16'(16'h1000 + i) || wr_data_log[i] !== line_data(8'(i))) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL max_write[%0d]: got addr %h expected %h",
                              i, wr_addr_log[i], 16'h1000 + i);
      end
    end
    checks++;
    if (wr_mask_log.size() == 1024 && (wr_mask_log[1023] !== 64'hFFFF_FFFF_FFFF_FFFE ||
                                       wr_mask_log[1022] !== 64'hFFFF_FFFF_FFFF_FFFF)) begin
      errors++;
      $display("FAIL max_last_mask: got %h expected fffffffffffffffe", wr_mask_log[1023]);
    end
    checks++;
    if (!to && (done_len_log[0] !== 16'hFFFF || done_flow_log[0] !== 6'd63)) begin
      errors++;
      $display("FAIL max_done: got len %h flow %0d expected ffff 63",
               done_len_log[0], done_flow_log[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wr_stall();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_rx_payload_mover.md
TCP_RX_PAYLOAD_MOVER -- requirements
Module: tcp_rx_payload_mover

Interface
REQ-001 Parameter DATA_W, 512, line width in bits; BYTES = DATA_W/8.
REQ-002 Parameter TMP_ADDR_W, 8, temp-buffer line address width.
REQ-003 Parameter DST_ADDR_W, 16, flow receive-buffer line address width.
REQ-004 Parameter LEN_W, 16, payload length width in bytes.
REQ-005 Parameter FLOWID_W, 6, flow identifier width.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 rst  in  1  asynchronous reset, asserted at 0.
REQ-009 req_val / req_rdy  in / out  1 / 1  move-request handshake.
REQ-010 req_slab_addr  in  TMP_ADDR_W  first temp-buffer line of payload.
REQ-011 req_len  in  LEN_W  payload bytes.
REQ-012 req_dst_addr  in  DST_ADDR_W  first destination line.
REQ-013 req_flowid  in  FLOWID_W  owning flow.
REQ-014 rd_req_val / rd_req_rdy / rd_req_addr  out / in / out  1 / 1 / TMP_ADDR_W  temp-buffer read request.
REQ-015 rd_resp_val / rd_resp_rdy / rd_resp_data  in / out / in  1 / 1 / DATA_W  temp-buffer read response, in request order.
REQ-016 wr_req_val / wr_req_rdy  out / in  1 / 1  flow-buffer write handshake.
REQ-017 wr_req_addr / wr_req_data / wr_req_mask  out  DST_ADDR_W / DATA_W / BYTES  write line, data, byte enables (bit BYTES-1 = byte 0 = data MSBs).
REQ-018 free_val / free_rdy / free_addr  out / in / out  1 / 1 / TMP_ADDR_W  slab release to the allocator.
REQ-019 done_val / done_rdy  out / in  1 / 1  completion handshake.
REQ-020 done_flowid / done_len  out  FLOWID_W / LEN_W  completed flow and byte count.

Function
REQ-021 FSM states: IDLE, COPY, FREE, DONE; req_rdy=1 only in IDLE.
REQ-022 IDLE, req_val&req_rdy: latch all req fields; lines = ceil(req_len/BYTES); ->COPY if lines!=0, else ->FREE.
REQ-023 COPY: rd_req_val=1 while rd_issued<lines; rd_req_addr = slab_addr + rd_issued (mod 2^TMP_ADDR_W); rd_issued increments on rd_req_val&rd_req_rdy.
REQ-024 COPY: wr_req_val = rd_resp_val; rd_resp_rdy = wr_req_rdy; wr_req_data = rd_resp_data, combinationally, no added latency.
REQ-025 wr_req_addr = dst_addr + wr_cnt (mod 2^DST_ADDR_W); wr_cnt increments on wr_req_val&wr_req_rdy.
REQ-026 wr_req_mask all ones except final line (wr_cnt==lines-1): top (req_len mod BYTES) bits set, all ones if remainder 0.
REQ-027 COPY->FREE on the handshake of the final write; reads and writes may overlap any number of outstanding lines.
REQ-028 FREE: free_val=1, free_addr=slab_addr; ->DONE on free_val&free_rdy.
REQ-029 DONE: done_val=1 with latched flowid and len; ->IDLE on done_val&done_rdy.
REQ-030 Outputs SHALL hold stable while val=1 and rdy=0.
REQ-031 rd_resp_val outside COPY SHALL be ignored (rd_resp_rdy=0).
REQ-032 Counters width LEN_W; req_len=2^LEN_W-1 SHALL complete correctly.

Reset
REQ-033 While rst=0: state=IDLE, counters=0, latched fields=0; req_rdy=0, all other val/rdy outputs=0, data/addr/mask outputs=0.
REQ-034 After rst rises: req_rdy=1 next cycle; reset mid-operation abandons the move with no free or done issued.

Verification
REQ-035 len=130, BYTES=64, slab=0x10, dst=0x200 -> 3 reads 0x10..0x12, writes 0x200..0x202, last mask top 2 bits only, free 0x10, done len=130.
REQ-036 len=0, flowid=5 -> no reads/writes, free slab then done flowid=5 len=0.
REQ-037 len=128, wr_req_rdy toggling 1/0 each cycle -> 2 writes, both masks all ones, data/addr stable while stalled.
REQ-038 slab=0xFF, len=192 -> read addresses 0xFF, 0x00, 0x01 (wrap).
REQ-039 free_rdy=0 for 10 cycles then done_rdy=0 for 5 -> free_val/done_val held, req_rdy=0 throughout, back-to-back request accepted on IDLE return.
REQ-040 rst=0 after 1 of 4 writes -> all valids 0 immediately; new request after release completes normally.
